// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared types and constants for the two-port RAM arbiter.
//   - state_t   : arbiter FSM states (IDLE, RMW_WR)
//   - WE_NONE   : byte-enable pattern for a read
//   - WE_FULL   : byte-enable pattern for a whole-word write
//   - is_partial: true when a byte-enable mask needs read-modify-write
package ram_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_FULL = 4'b1111;

  function automatic logic is_partial(input logic [3:0] we);
    return (we != WE_NONE) && (we != WE_FULL);
  endfunction

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// byte_merge
//   Combinational byte merge for read-modify-write.
//   Ports:
//     old_word [31:0] in  : word read back from the RAM
//     new_word [31:0] in  : write data from the requester
//     mask     [3:0]  in  : byte enables, bit i selects new_word byte i
//     merged   [31:0] out : per byte, mask[i] ? new_word byte : old_word byte
module byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  mask,
  output logic [31:0] merged
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign merged[gi*8 +: 8] = mask[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-cycle RAM port between two requesters with
//   round-robin arbitration. Partial byte writes are turned into a
//   read followed by a full-word write of the merged data, so the RAM
//   only ever sees byte enables of 0000 or 1111.
//   Ports:
//     clk, rst (synchronous, active-low)
//     reqN_valid/ready/addr/wdata/we : requester N request channel
//     rspN_valid, rsp_rdata          : one-cycle completion pulse + data
//     ram_oe/addr/wdata/we, ram_rdata: RAM port (registered read,
//                                      write-first)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int SCALE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [SCALE-1:0] req0_addr,
  input  logic [31:0]      req0_wdata,
  input  logic [3:0]       req0_we,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [SCALE-1:0] req1_addr,
  input  logic [31:0]      req1_wdata,
  input  logic [3:0]       req1_we,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [31:0]      rsp_rdata,
  output logic             ram_oe,
  output logic [SCALE-1:0] ram_addr,
  output logic [31:0]      ram_wdata,
  output logic [3:0]       ram_we,
  input  logic [31:0]      ram_rdata
);

  state_t state_reg;
  state_t state_next;

  // 1 when requester 1 won the most recent accept; reset to 1 so that
  // requester 0 wins the first contention.
  logic             last_grant_reg;

  logic [SCALE-1:0] lat_addr_reg;
  logic [31:0]      lat_wdata_reg;
  logic [3:0]       lat_we_reg;
  logic             lat_id_reg;

  logic [1:0]       rsp_reg;
  logic [1:0]       rsp_next;

  logic             grant_id;
  logic             accept;
  logic [SCALE-1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_we;
  logic             sel_partial;
  logic [31:0]      merged_word;

  // ---------------- arbitration ----------------
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_reg;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end else begin
      grant_id = 1'b0;
    end
  end

  assign accept      = rst && (state_reg == IDLE) && (req0_valid || req1_valid);
  assign sel_addr    = grant_id ? req1_addr  : req0_addr;
  assign sel_wdata   = grant_id ? req1_wdata : req0_wdata;
  assign sel_we      = grant_id ? req1_we    : req0_we;
  assign sel_partial = is_partial(sel_we);

  // ram_rdata in RMW_WR holds the word read during the accept cycle.
  byte_merge u_byte_merge (
    .old_word (ram_rdata),
    .new_word (lat_wdata_reg),
    .mask     (lat_we_reg),
    .merged   (merged_word)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept && sel_partial) begin
          state_next = RMW_WR;
        end
      end
      RMW_WR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Everything is gated by rst so that a reset landing in RMW_WR
  // suppresses the write-back in that very cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ram_oe     = 1'b0;
    ram_we     = WE_NONE;
    ram_addr   = sel_addr;
    ram_wdata  = sel_wdata;
    if (rst) begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
            ram_oe     = 1'b1;
            ram_we     = sel_partial ? WE_NONE : sel_we;
          end
        end
        RMW_WR: begin
          ram_oe    = 1'b1;
          ram_we    = WE_FULL;
          ram_addr  = lat_addr_reg;
          ram_wdata = merged_word;
        end
        default: begin
          ram_oe = 1'b0;
        end
      endcase
    end
  end

  // ---------------- response scheduling ----------------
  always_comb begin
    rsp_next = 2'b00;
    if (state_reg == RMW_WR) begin
      rsp_next[lat_id_reg] = 1'b1;
    end else if (accept && !sel_partial) begin
      rsp_next[grant_id] = 1'b1;
    end
  end

  // ---------------- pointer, latches, responses ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_reg <= 1'b1;
      rsp_reg        <= 2'b00;
      lat_addr_reg   <= '0;
      lat_wdata_reg  <= '0;
      lat_we_reg     <= WE_NONE;
      lat_id_reg     <= 1'b0;
    end else begin
      rsp_reg <= rsp_next;
      if (accept) begin
        last_grant_reg <= grant_id;
      end
      // Only an accepted partial write is captured; unaccepted payloads
      // are never sampled.
      if (accept && sel_partial) begin
        lat_addr_reg  <= sel_addr;
        lat_wdata_reg <= sel_wdata;
        lat_we_reg    <= sel_we;
        lat_id_reg    <= grant_id;
      end
    end
  end

  assign rsp0_valid = rsp_reg[0];
  assign rsp1_valid = rsp_reg[1];
  assign rsp_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Table-driven bench for ram_arbiter with a behavioural RAM
//   (registered read, write-first). One table row per clock cycle;
//   a hand-written sequence covers reset in the middle of a
//   read-modify-write.
module tb_ram_arbiter;

  localparam int SCALE = 10;
  localparam logic [3:0]  N = 4'h0;
  localparam logic [3:0]  F = 4'hF;
  localparam logic [31:0] Z = 32'h0;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [SCALE-1:0] req0_addr, req1_addr;
  logic [31:0]      req0_wdata, req1_wdata;
  logic [3:0]       req0_we, req1_we;
  logic             rsp0_valid, rsp1_valid;
  logic [31:0]      rsp_rdata;
  logic             ram_oe;
  logic [SCALE-1:0] ram_addr;
  logic [31:0]      ram_wdata;
  logic [3:0]       ram_we;
  logic [31:0]      ram_rdata;

  logic [31:0] mem [0:(1<<SCALE)-1];

  int n_checks = 0;
  int n_errors = 0;
  logic monitor_on = 1'b0;

  ram_arbiter #(.SCALE(SCALE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_we    (req0_we),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_we    (req1_we),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_rdata  (rsp_rdata),
    .ram_oe     (ram_oe),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, write-first.
  always @(posedge clk) begin
    if (ram_oe) begin
      if (ram_we == F) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every cycle: RAM byte enables must be whole-word, responses exclusive.
  always @(negedge clk) begin
    if (monitor_on) begin
      n_checks++;
      if (ram_we !== N && ram_we !== F) begin
        n_errors++;
        $display("FAIL mon_ram_we: got %h expected 0 or f", ram_we);
      end
      n_checks++;
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
        n_errors++;
        $display("FAIL mon_rsp_excl: got rsp0=1 rsp1=1 expected at most one");
      end
    end
  end

  typedef struct {
    logic             v0;
    logic [SCALE-1:0] a0;
    logic [3:0]       we0;
    logic [31:0]      wd0;
    logic             v1;
    logic [SCALE-1:0] a1;
    logic [3:0]       we1;
    logic [31:0]      wd1;
    logic             r0;
    logic             r1;
    logic             oe;
    logic [3:0]       rwe;
    logic [SCALE-1:0] raddr;
    logic             chk_wd;
    logic [31:0]      rwd;
    logic             rsp0;
    logic             rsp1;
    logic [31:0]      rdata;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vec [NVEC];

  task automatic drive_idle();
    req0_valid = 1'b0; req0_addr = '0; req0_we = N; req0_wdata = Z;
    req1_valid = 1'b0; req1_addr = '0; req1_we = N; req1_wdata = Z;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Stimulus table: inputs | ready0 ready1 oe we addr chk_wd wdata | rsp0 rsp1 rdata
    // Contention after reset: grants alternate starting with req0.
    vec[0]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b1,1'b0,1'b1,N,10'd16,1'b0,Z, 1'b0,1'b0,Z};
    vec[1]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b0,1'b1,1'b1,N,10'd17,1'b0,Z, 1'b1,1'b0,32'hA0000010};
    vec[2]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b1,1'b0,1'b1,N,10'd16,1'b0,Z, 1'b0,1'b1,32'hA0000011};
    vec[3]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b0,1'b1,1'b1,N,10'd17,1'b0,Z, 1'b1,1'b0,32'hA0000010};
    vec[4]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b1,1'b0,1'b1,N,10'd16,1'b0,Z, 1'b0,1'b1,32'hA0000011};
    vec[5]  = '{1'b1,10'd16,N,Z, 1'b1,10'd17,N,Z, 1'b0,1'b1,1'b1,N,10'd17,1'b0,Z, 1'b1,1'b0,32'hA0000010};
    vec[6]  = '{1'b0,10'd0,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b0,N,10'd0,1'b0,Z,  1'b0,1'b1,32'hA0000011};
    // Single read of addr 5.
    vec[7]  = '{1'b1,10'd5,N,Z,  1'b0,10'd0,N,Z,  1'b1,1'b0,1'b1,N,10'd5,1'b0,Z,  1'b0,1'b0,Z};
    vec[8]  = '{1'b0,10'd0,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b0,N,10'd0,1'b0,Z,  1'b1,1'b0,32'h11223344};
    // Full write then read back with no bubble.
    vec[9]  = '{1'b1,10'd7,F,32'hDEADBEEF, 1'b0,10'd0,N,Z, 1'b1,1'b0,1'b1,F,10'd7,1'b1,32'hDEADBEEF, 1'b0,1'b0,Z};
    vec[10] = '{1'b1,10'd7,N,Z,  1'b0,10'd0,N,Z,  1'b1,1'b0,1'b1,N,10'd7,1'b0,Z,  1'b1,1'b0,32'hDEADBEEF};
    vec[11] = '{1'b0,10'd0,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b0,N,10'd0,1'b0,Z,  1'b1,1'b0,32'hDEADBEEF};
    // Partial write from req1; req0 waits through the RMW_WR cycle.
    vec[12] = '{1'b0,10'd0,N,Z,  1'b1,10'd3,4'b0011,32'hAAAABBBB, 1'b0,1'b1,1'b1,N,10'd3,1'b0,Z, 1'b0,1'b0,Z};
    vec[13] = '{1'b1,10'd5,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b1,F,10'd3,1'b1,32'h1234BBBB, 1'b0,1'b0,Z};
    vec[14] = '{1'b1,10'd5,N,Z,  1'b0,10'd0,N,Z,  1'b1,1'b0,1'b1,N,10'd5,1'b0,Z,  1'b0,1'b1,32'h1234BBBB};
    vec[15] = '{1'b0,10'd0,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b0,N,10'd0,1'b0,Z,  1'b1,1'b0,32'h11223344};
    vec[16] = '{1'b0,10'd0,N,Z,  1'b1,10'd3,N,Z,  1'b0,1'b1,1'b1,N,10'd3,1'b0,Z,  1'b0,1'b0,Z};
    vec[17] = '{1'b0,10'd0,N,Z,  1'b0,10'd0,N,Z,  1'b0,1'b0,1'b0,N,10'd0,1'b0,Z,  1'b0,1'b1,32'h1234BBBB};

    for (int i = 0; i < (1 << SCALE); i++) mem[i] = 32'hA0000000 | 32'(i);
    mem[5] = 32'h11223344;
    mem[3] = 32'h12345678;

    // ---------------- reset with both requesters pushing ----------------
    rst = 1'b0;
    drive_idle();
    req0_valid = 1'b1; req0_addr = 10'd16;
    req1_valid = 1'b1; req1_addr = 10'd17;
    monitor_on = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset ready0", 32'(req0_ready), 32'd0);
      chk("reset ready1", 32'(req1_ready), 32'd0);
      chk("reset ram_oe", 32'(ram_oe), 32'd0);
      chk("reset ram_we", 32'(ram_we), 32'd0);
      chk("reset rsp0", 32'(rsp0_valid), 32'd0);
      chk("reset rsp1", 32'(rsp1_valid), 32'd0);
      next_cycle();
    end
    rst = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NVEC; i++) begin
      req0_valid = vec[i].v0; req0_addr = vec[i].a0; req0_we = vec[i].we0; req0_wdata = vec[i].wd0;
      req1_valid = vec[i].v1; req1_addr = vec[i].a1; req1_we = vec[i].we1; req1_wdata = vec[i].wd1;
      @(negedge clk);
      $display("row %0d: ready=%b%b oe=%b we=%h addr=%0d wdata=%h rsp=%b%b rdata=%h",
               i, req0_ready, req1_ready, ram_oe, ram_we, ram_addr, ram_wdata,
               rsp0_valid, rsp1_valid, rsp_rdata);
      chk($sformatf("row%0d ready0", i), 32'(req0_ready), 32'(vec[i].r0));
      chk($sformatf("row%0d ready1", i), 32'(req1_ready), 32'(vec[i].r1));
      chk($sformatf("row%0d ram_oe", i), 32'(ram_oe), 32'(vec[i].oe));
      chk($sformatf("row%0d ram_we", i), 32'(ram_we), 32'(vec[i].rwe));
      if (vec[i].oe) chk($sformatf("row%0d ram_addr", i), 32'(ram_addr), 32'(vec[i].raddr));
      if (vec[i].chk_wd) chk($sformatf("row%0d ram_wdata", i), ram_wdata, vec[i].rwd);
      chk($sformatf("row%0d rsp0", i), 32'(rsp0_valid), 32'(vec[i].rsp0));
      chk($sformatf("row%0d rsp1", i), 32'(rsp1_valid), 32'(vec[i].rsp1));
      if (vec[i].rsp0 || vec[i].rsp1) chk($sformatf("row%0d rsp_rdata", i), rsp_rdata, vec[i].rdata);
      next_cycle();
    end

    // ---------------- reset during RMW_WR ----------------
    // req1 was granted last, so a lone req0 partial write is accepted.
    drive_idle();
    req0_valid = 1'b1; req0_addr = 10'd9; req0_we = 4'b0001; req0_wdata = 32'h000000FF;
    @(negedge clk);
    $display("rmw-reset accept: ready0=%b oe=%b we=%h", req0_ready, ram_oe, ram_we);
    chk("rmwrst accept ready0", 32'(req0_ready), 32'd1);
    chk("rmwrst accept ram_we", 32'(ram_we), 32'(N));
    next_cycle();
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    $display("rmw-reset write-back cycle: oe=%b we=%h", ram_oe, ram_we);
    chk("rmwrst wb ram_oe", 32'(ram_oe), 32'd0);
    chk("rmwrst wb ram_we", 32'(ram_we), 32'(N));
    next_cycle();
    req0_valid = 1'b1; req0_addr = 10'd16;
    req1_valid = 1'b1; req1_addr = 10'd17;
    @(negedge clk);
    $display("rmw-reset held: ready=%b%b rsp=%b%b", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
    chk("rmwrst rsp0", 32'(rsp0_valid), 32'd0);
    chk("rmwrst rsp1", 32'(rsp1_valid), 32'd0);
    chk("rmwrst ready0", 32'(req0_ready), 32'd0);
    chk("rmwrst ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    $display("post-reset contention: ready=%b%b addr=%0d", req0_ready, req1_ready, ram_addr);
    chk("postrst ready0", 32'(req0_ready), 32'd1);
    chk("postrst ready1", 32'(req1_ready), 32'd0);
    chk("postrst ram_addr", 32'(ram_addr), 32'd16);
    chk("postrst no rsp0", 32'(rsp0_valid), 32'd0);
    chk("postrst mem9", mem[9], 32'hA0000009);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    $display("post-reset req1: ready1=%b rsp0=%b rdata=%h", req1_ready, rsp0_valid, rsp_rdata);
    chk("postrst2 ready1", 32'(req1_ready), 32'd1);
    chk("postrst2 rsp0", 32'(rsp0_valid), 32'd1);
    chk("postrst2 rdata", rsp_rdata, 32'hA0000010);
    next_cycle();
    drive_idle();
    @(negedge clk);
    $display("post-reset final: rsp1=%b rdata=%h", rsp1_valid, rsp_rdata);
    chk("postrst3 rsp1", 32'(rsp1_valid), 32'd1);
    chk("postrst3 rdata", rsp_rdata, 32'hA0000011);
    chk("postrst3 mem9", mem[9], 32'hA0000009);
    next_cycle();

    monitor_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
